// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: sequencer states, instruction field
// positions, branch condition encodings and execution-unit flag bit indices.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_e;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 28;
  localparam int COND_HI   = 27;
  localparam int COND_LO   = 26;
  localparam int JMP_HI    = 25;
  localparam int JMP_LO    = 23;

  localparam logic [1:0] COND_NEVER  = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b11;

  localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/branch_resolve.sv
// Combinational next-PC computation: sequential step or relative forward jump,
// gated by the branch condition against the flags of the previous instruction.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic [1:0]      cond_i,
  input  logic [2:0]      jmp_i,
  input  logic [3:0]      flag_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic taken_s;
  logic unused_s;

  assign unused_s = ^flag_i[3:2];

  // Branch decision and wrap-around target
  always_comb begin
    taken_s = 1'b0;
    case (cond_i)
      COND_NEVER:  taken_s = 1'b0;
      COND_Z:      taken_s = flag_i[FLAG_Z];
      COND_C:      taken_s = flag_i[FLAG_C];
      COND_ALWAYS: taken_s = 1'b1;
      default:     taken_s = 1'b0;
    endcase
    if (taken_s) begin
      next_pc_o = pc_i + PC_W'(1'b1) + PC_W'(jmp_i);
    end else begin
      next_pc_o = pc_i + PC_W'(1'b1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, reads the synchronous instruction
// memory and presents each instruction to the control unit for one execute cycle.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = {PC_W{1'b0}},
  parameter logic [3:0]      HALT_OP    = HALT_OP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            exec_en,
  input  logic [3:0]      flag,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, next_pc_s;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      flag_q, flag_d;
  logic [15:0]     retired_q, retired_d;
  logic            imem_en_q, exec_en_q, busy_q, halted_q;

  branch_resolve #(.PC_W(PC_W)) u_branch_resolve (
    .cond_i    (instr_q[COND_HI:COND_LO]),
    .jmp_i     (instr_q[JMP_HI:JMP_LO]),
    .flag_i    (flag_q),
    .pc_i      (pc_q),
    .next_pc_o (next_pc_s)
  );

  // Sequencer next-state; start is only honoured from IDLE or HALT
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    flag_d    = flag_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = START_ADDR;
          flag_d    = 4'h0;
          retired_d = 16'h0000;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (imem_rdata[OPCODE_HI:OPCODE_LO] == HALT_OP) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
          instr_d = imem_rdata;
        end
      end
      ST_EXEC: begin
        state_d   = ST_FETCH;
        pc_d      = next_pc_s;
        flag_d    = flag;
        retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_ADDR;
      instr_q   <= 32'h0000_0000;
      flag_q    <= 4'h0;
      retired_q <= 16'h0000;
      imem_en_q <= 1'b0;
      exec_en_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      flag_q    <= flag_d;
      retired_q <= retired_d;
      imem_en_q <= (state_d == ST_FETCH);
      exec_en_q <= (state_d == ST_EXEC);
      busy_q    <= (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  assign imem_en   = imem_en_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign exec_en   = exec_en_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level reference model predicts
// every execute pulse and halt; a negedge monitor pops and compares.
module tb_instr_sequencer;

  localparam int PC_W     = 4;
  localparam int DEPTH    = 16;
  localparam int START    = 0;
  localparam int MAX_EXEC = 25;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic            exec_en;
  logic [3:0]      flag;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic [15:0]     retired;

  instr_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .exec_en(exec_en), .flag(flag), .pc(pc),
    .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  logic [3:0]  junk = 4'h0;
  int          cyc = 0;
  int          t0 = 0;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) junk <= 4'($urandom);

  // Execution unit stand-in: each instruction carries the flags it produces in bits 3:0
  assign flag = exec_en ? instr[3:0] : junk;

  typedef struct {
    logic [31:0] instr;
    int          pc;
    int          ret;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        halt_q[$];
  logic [31:0] model_instr = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        halted_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] c,
                                     input logic [2:0] j, input logic [3:0] fl);
    logic [18:0] mid;
    mid = 19'($urandom);
    return {op, c, j, mid, fl};
  endfunction

  // Walk the program from START; returns 1 if it reaches a halt within MAX_EXEC
  function automatic bit run_model();
    int          pcm = START;
    logic [3:0]  fq = 4'h0;
    logic [31:0] w;
    bit          taken;
    for (int n = 0; n < MAX_EXEC; n++) begin
      w = mem[pcm];
      if (w[31:28] == 4'hF) begin
        halt_q.push_back('{model_instr, pcm, n, 3 * n + 3});
        return 1'b1;
      end
      exp_q.push_back('{w, pcm, n, 3 * n + 3});
      case (w[27:26])
        2'b00:   taken = 1'b0;
        2'b01:   taken = fq[0];
        2'b10:   taken = fq[1];
        default: taken = 1'b1;
      endcase
      pcm = (pcm + 1 + (taken ? int'(w[25:23]) : 0)) % DEPTH;
      fq = w[3:0];
      model_instr = w;
    end
    return 1'b0;
  endfunction

  // Monitor: every exec pulse and every halt entry is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exec_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_exec: got exec_en=1 at pc %0h expected none", pc);
        end else begin
          e = exp_q.pop_front();
          chk("exec_instr", instr, e.instr);
          chk("exec_pc", pc, e.pc);
          chk("exec_retired", retired, e.ret);
          chk("exec_cycle", cyc - t0, e.cyc);
          chk("exec_busy", busy, 1);
        end
      end
      if (imem_en) chk("addr_is_pc", imem_addr, pc);
      if (halted && !halted_prev) begin
        if (halt_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_halt: got halted=1 expected none");
        end else begin
          e = halt_q.pop_front();
          chk("halt_pc", pc, e.pc);
          chk("halt_retired", retired, e.ret);
          chk("halt_instr_kept", instr, e.instr);
          chk("halt_cycle", cyc - t0, e.cyc);
          chk("halt_busy", busy, 0);
        end
      end
    end
    halted_prev <= halted;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_exec_en"}, exec_en, 0);
    chk({tag, "_imem_en"}, imem_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_pc"}, pc, START);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_retired"}, retired, 0);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(4'hF, 2'($urandom), 3'($urandom), 4'($urandom));
  endtask

  // Start the program in mem and wait for the scoreboard to drain; stray starts while busy
  task automatic run_prog();
    bit will_halt;
    int guard = 0;
    will_halt = run_model();
    @(negedge clk);
    #1;
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("start_pc", pc, START);
    chk("start_retired", retired, 0);
    chk("start_fetch", imem_en, 1);
    chk("start_halted", halted, 0);
    while ((exp_q.size() > 0 || halt_q.size() > 0) && guard < 400) begin
      @(negedge clk);
      #1;
      start = busy && ($urandom_range(0, 3) == 0);
      guard++;
    end
    start = 1'b0;
    if (guard >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending expected 0", exp_q.size() + halt_q.size());
      exp_q.delete();
      halt_q.delete();
    end
    if (!will_halt) begin
      rst_n = 1'b0;
      model_instr = 32'h0;
      #1;
      check_reset_vals("loop_rst");
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    fill_halt();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_vals("idle");

    // three plain instructions then halt
    fill_halt();
    for (int i = 0; i < 3; i++) mem[i] = mk(4'h1, 2'b00, 3'($urandom), 4'($urandom));
    run_prog();
    chk("progA_pc", pc, 3);
    chk("progA_retired", retired, 3);
    chk("progA_halted", halted, 1);

    // jump on zero, taken then not taken
    for (int rep = 0; rep < 2; rep++) begin
      fill_halt();
      mem[0] = mk(4'h2, 2'b00, 3'd0, (rep == 0) ? 4'b0001 : 4'b0000);
      mem[1] = mk(4'h3, 2'b01, 3'd3, 4'h0);
      mem[5] = mk(4'h4, 2'b00, 3'd0, 4'h0);
      run_prog();
      chk("jz_final_pc", pc, (rep == 0) ? 6 : 2);
    end

    // unconditional jumps reaching pc 14, then wrap to 1
    fill_halt();
    mem[0]  = mk(4'h5, 2'b11, 3'd7, 4'h0);
    mem[8]  = mk(4'h6, 2'b11, 3'd5, 4'h0);
    mem[14] = mk(4'h7, 2'b11, 3'd2, 4'h0);
    run_prog();
    chk("wrap_pc", pc, 1);

    // never-condition with all flags set
    fill_halt();
    mem[0] = mk(4'h1, 2'b00, 3'd0, 4'hF);
    mem[1] = mk(4'h1, 2'b00, 3'd7, 4'h0);
    mem[2] = mk(4'h1, 2'b00, 3'd0, 4'h0);
    run_prog();
    chk("never_pc", pc, 3);

    // reset dropped in DECODE
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(4'h1, 2'b00, 3'd0, 4'h0);
    @(negedge clk);
    #1;
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_instr = 32'h0;
    #1;
    check_reset_vals("decode_rst");
    repeat (2) @(negedge clk);
    chk("decode_rst_no_exec", exec_en, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_reset_vals("after_release");

    // random programs, some looping until the cap forces a reset
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = mk(($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                    2'($urandom), 3'($urandom), 4'($urandom));
      end
      run_prog();
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/execute sequencer for the 8-bit microprocessor. It owns the program counter and reads 32-bit instruction words from a synchronous instruction memory. It presents each word to `control_unit` for exactly one execute cycle and resolves conditional jumps from the execution-unit flags. It sits between instruction memory and `control_unit`/`execution_unit` and is the only block that advances the PC.

## Interface
Parameters:
- `PC_W`, default 8: program counter / instruction-memory address width.
- `START_ADDR`, default 0: PC value loaded on reset and on every `start`.
- `HALT_OP`, default 4'hF: opcode that stops the sequencer.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that begins execution from `START_ADDR`. It is honoured only in IDLE or HALT.
- `imem_en`, out, 1: instruction-memory read enable.
- `imem_addr`, out, PC_W: read address. It always equals `pc`.
- `imem_rdata`, in, 32: read data, valid exactly one cycle after `imem_en`.
- `instr`, out, 32: registered instruction word driven to `control_unit.address[31:0]`.
- `exec_en`, out, 1: high for exactly one cycle per executed instruction.
- `flag`, in, 4: flags from `execution_unit`, valid during the `exec_en` cycle.
- `pc`, out, PC_W: current program counter.
- `busy`, out, 1: high in FETCH, DECODE and EXEC.
- `halted`, out, 1: high in HALT.
- `retired`, out, 16: count of executed instructions since the last `start`.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH → DECODE, always.
  - DECODE → EXEC, or DECODE → HALT if the opcode equals `HALT_OP`.
  - EXEC → FETCH, always.
  - HALT → FETCH on `start`.
- FETCH: `imem_en`=1, `imem_addr`=`pc`.
- DECODE: `instr` ← `imem_rdata`. The opcode check uses `imem_rdata[31:28]`. A HALT instruction is never loaded into `instr`: `instr` keeps its previous value and `exec_en` stays low.
- EXEC:
  - `exec_en`=1.
  - `flag_q` ← `flag`.
  - `retired` ← `retired`+1, saturating at 16'hFFFF.
  - `pc` is updated (jump rules below).
- Instruction fields used: cond=`instr[27:26]`, jmp=`instr[25:23]`.
- Branch condition, evaluated against `flag_q` (the flags latched from the previous executed instruction):
  - 00: never.
  - 01: if `flag_q[0]` (zero).
  - 10: if `flag_q[1]` (carry).
  - 11: always.
- Next PC:
  - taken: `pc` + 1 + jmp.
  - not taken: `pc` + 1.
  - Arithmetic is unsigned modulo 2^PC_W; wrap-around is silent.
- Every `start` sets `pc` ← `START_ADDR`, `flag_q` ← 0 and `retired` ← 0. `instr` is not cleared.
- `start` in FETCH, DECODE or EXEC is ignored and has no side effects.
- `halted` is cleared when leaving HALT.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state=IDLE, `pc`=`START_ADDR`, `instr`=0, `flag_q`=0, `retired`=0.
  - `exec_en`=0, `imem_en`=0, `busy`=0, `halted`=0.
- Throughput: 3 cycles per instruction. `exec_en` pulses on cycles 3, 6, 9… after the `start` cycle (the `start` cycle is cycle 0).
- Latency from `start` to the first `imem_en` is 1 cycle.
- A HALT instruction costs 2 cycles (FETCH, DECODE). `halted` rises on the cycle after DECODE.
- `pc` changes only on the EXEC→FETCH edge or on `start`. It is stable through FETCH and DECODE.
- `flag` is sampled only on the `exec_en` edge. Its value in other cycles is don't-care.
- Reset asserted mid-instruction: immediate return to reset values. No partial `exec_en` pulse occurs after `rst_n` falls.

## Structure
- Shared package `cpu_pkg` holds:
  - state enum;
  - field position constants: OPCODE 31:28, COND 27:26, JMP 25:23;
  - cond encodings: COND_NEVER, COND_Z, COND_C, COND_ALWAYS;
  - `HALT_OP` default;
  - flag bit indices: FLAG_Z=0, FLAG_C=1.
- One sub-module is natural: `branch_resolve`. It is combinational and takes cond, jmp, `flag_q` and `pc`, returning the next PC. The FSM, PC, `instr`/`flag_q` registers and the counter stay in `instr_sequencer`.

## Test plan
- Reset then `start`, with memory holding 3 non-branch instructions then opcode F:
  - `exec_en` pulses at cycles 3, 6, 9;
  - `pc` goes 0→1→2→3;
  - `halted`=1 at cycle 12;
  - `retired`=3.
- Conditional jump on zero: instruction at 0 makes the execution unit drive `flag`=4'b0001. The instruction at 1 has cond=01, jmp=3. Required: next fetch address is 5. Repeat with `flag`=0; required next fetch address is 2.
- Unconditional wrap-around: PC_W=4, pc=14, cond=11, jmp=2. Required: next pc is (14+1+2) mod 16 = 1.
- `start` pulsed during EXEC: no state change, `pc` and `retired` unaffected. `start` pulsed in HALT: `pc`=`START_ADDR`, `retired`=0, fetch resumes the next cycle.
- `rst_n` dropped during DECODE:
  - all outputs take their reset values asynchronously;
  - no `exec_en` pulse follows;
  - after release, nothing happens until `start`.
- Cond 00 with jmp=7 while `flag_q`=4'hF: the branch is not taken and `pc` increments by 1.
